// File: rtl/phy_tx_if.sv
// rtl/phy_tx_if.sv - valid/ready word handshake feeding the 2-lane PHY transmitter
interface phy_tx_if;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/phy_tx.sv
// rtl/phy_tx.sv - 2-lane byte-striped MSB-first serializer with post-reset COM burst and IDL fill
// Optional periodic COM insertion when PHY_TX_SKP_EN is defined.
module phy_tx #(
    parameter int unsigned ALIGN_WORDS  = 4,
    parameter logic [7:0]  COM          = 8'hBC,
    parameter logic [7:0]  IDL          = 8'h7C,
    parameter int unsigned SKP_INTERVAL = 64
) (
    input  logic    clk_32f,
    input  logic    reset,
    phy_tx_if.slave up,
    output logic    data_out_0,
    output logic    data_out_1
);
    localparam int unsigned AW = $clog2(ALIGN_WORDS + 1);

    if (ALIGN_WORDS < 1 || SKP_INTERVAL < 2) begin : g_param_check
        $error("phy_tx: ALIGN_WORDS must be >= 1 and SKP_INTERVAL >= 2");
    end

    typedef enum logic {ALIGN, ACTIVE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    bit_cnt;
    logic [AW-1:0] align_cnt, align_cnt_d;
    logic [15:0]   sh0, sh1;
    logic [31:0]   hold_data;
    logic          hold_full;
    logic [31:0]   load_word;
    logic          load_edge, skp_due, xfer, consume, ready;

    assign load_edge    = (bit_cnt == 4'd15);
    assign xfer         = up.valid_in & ready;
    assign up.ready_out = ready;

`ifdef PHY_TX_SKP_EN
    localparam int unsigned SW = $clog2(SKP_INTERVAL);
    logic [SW-1:0] slot_cnt;

    assign skp_due = (slot_cnt == SW'(SKP_INTERVAL - 1));

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
        end else if (load_edge && state_q == ACTIVE) begin
            slot_cnt <= skp_due ? '0 : slot_cnt + 1'b1;
        end
    end
`else
    assign skp_due = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        align_cnt_d = align_cnt;
        load_word   = {4{IDL}};
        consume     = 1'b0;
        ready       = 1'b0;
        case (state_q)
            ALIGN: begin
                load_word = {4{COM}};
                if (load_edge) begin
                    align_cnt_d = align_cnt + 1'b1;
                    if (align_cnt == AW'(ALIGN_WORDS - 1)) begin
                        state_d = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                // A full buffer may be refilled only on the edge that drains it.
                ready = !hold_full || (load_edge && !skp_due);
                if (skp_due) begin
                    load_word = {4{COM}};
                end else if (hold_full) begin
                    load_word = hold_data;
                    consume   = load_edge;
                end
            end
            default: state_d = ALIGN;
        endcase
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q    <= ALIGN;
            align_cnt  <= '0;
            bit_cnt    <= 4'd15;
            sh0        <= '0;
            sh1        <= '0;
            data_out_0 <= 1'b0;
            data_out_1 <= 1'b0;
            hold_data  <= '0;
            hold_full  <= 1'b0;
        end else begin
            state_q   <= state_d;
            align_cnt <= align_cnt_d;
            bit_cnt   <= bit_cnt + 1'b1;
            // The lane register shows the MSB of a freshly loaded word in the very next cycle.
            if (load_edge) begin
                sh0        <= {load_word[31:24], load_word[15:8]};
                sh1        <= {load_word[23:16], load_word[7:0]};
                data_out_0 <= load_word[31];
                data_out_1 <= load_word[23];
            end else begin
                sh0        <= {sh0[14:0], 1'b0};
                sh1        <= {sh1[14:0], 1'b0};
                data_out_0 <= sh0[14];
                data_out_1 <= sh1[14];
            end
            if (xfer) begin
                hold_data <= up.data_in;
                hold_full <= 1'b1;
            end else if (consume) begin
                hold_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_phy_tx.sv
// tb/tb_phy_tx.sv - directed self-checking bench for phy_tx
module tb_phy_tx;
    logic clk = 1'b0;
    logic reset;
    logic d0, d1;
    int   checks = 0;
    int   errors = 0;
    int   sn = 0;
    logic lane0_log [0:1023];
    logic lane1_log [0:1023];

    phy_tx_if bus ();

    phy_tx dut (
        .clk_32f    (clk),
        .reset      (reset),
        .up         (bus),
        .data_out_0 (d0),
        .data_out_1 (d1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        sn++;
        lane0_log[sn] = d0;
        lane1_log[sn] = d1;
    endtask

    task automatic chk_bits(input string tag, input int first, input int n,
                            input logic [15:0] e0, input logic [15:0] e1);
        logic [15:0] l0, l1;
        l0 = '0;
        l1 = '0;
        for (int i = 0; i < n; i++) begin
            l0 = {l0[14:0], lane0_log[first + i]};
            l1 = {l1[14:0], lane1_log[first + i]};
        end
        chk({tag, "_lane0"}, {16'h0, l0}, {16'h0, e0});
        chk({tag, "_lane1"}, {16'h0, l1}, {16'h0, e1});
    endtask

    task automatic send(input logic [31:0] w, output int waited);
        logic took;
        bus.data_in  = w;
        bus.valid_in = 1'b1;
        waited = 0;
        forever begin
            took = bus.ready_out;
            step();
            waited++;
            if (took) break;
            if (waited >= 40) begin
                checks++;
                errors++;
                $error("FAIL send_timeout: word %h not accepted after %0d cycles, required <= 40", w, waited);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int base;
        bus.data_in  = '0;
        bus.valid_in = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_lane0", 32'(d0), 32'd0);
        chk("rst_lane1", 32'(d1), 32'd0);
        chk("rst_ready", 32'(bus.ready_out), 32'd0);

        // Alignment burst; first load edge is the first posedge after release.
        reset = 1'b0;
        for (int i = 0; i < 48; i++) begin
            step();
            chk("align_ready_low", 32'(bus.ready_out), 32'd0);
        end
        step();
        chk("ready_rise", 32'(bus.ready_out), 32'd1);

        send(32'hDEADBEEF, w);
        chk("deadbeef_wait", 32'(w), 32'd1);
        bus.valid_in = 1'b0;
        chk("ready_hold_full", 32'(bus.ready_out), 32'd0);
        while (sn < 64) step();
        step();
        chk("ready_after_load", 32'(bus.ready_out), 32'd1);

        // Three idle slots, then a word offered at bit_cnt 15 followed by a stream.
        while (sn < 128) step();
        send(32'h12345678, w);
        chk("w12345678_wait", 32'(w), 32'd1);
        send(32'h01234567, w);
        chk("w01234567_wait", 32'(w), 32'd16);
        send(32'h89ABCDEF, w);
        chk("w89ABCDEF_wait", 32'(w), 32'd16);
        send(32'h00FF00FF, w);
        chk("w00FF00FF_wait", 32'(w), 32'd16);
        bus.valid_in = 1'b0;

        // Reset mid data word with the hold buffer full.
        while (sn < 224) step();
        send(32'hA5C35A3C, w);
        chk("wA5C35A3C_wait", 32'(w), 32'd1);
        send(32'hCAFEF00D, w);
        chk("wCAFEF00D_wait", 32'(w), 32'd16);
        bus.valid_in = 1'b0;
        while (sn < 248) step();
        reset = 1'b1;
        #1;
        chk("midrst_lane0", 32'(d0), 32'd0);
        chk("midrst_lane1", 32'(d1), 32'd0);
        chk("midrst_ready", 32'(bus.ready_out), 32'd0);
        repeat (2) step();
        base = sn;
        reset = 1'b0;
        while (sn < base + 48) step();
        chk("realign_ready_low", 32'(bus.ready_out), 32'd0);
        step();
        chk("realign_ready_rise", 32'(bus.ready_out), 32'd1);
        while (sn < base + 96) step();

        for (int s = 0; s < 4; s++) chk_bits("com_burst", 1 + 16 * s, 16, 16'hBCBC, 16'hBCBC);
        chk_bits("deadbeef", 65, 16, 16'hDEBE, 16'hADEF);
        for (int s = 0; s < 4; s++) chk_bits("idle", 81 + 16 * s, 16, 16'h7C7C, 16'h7C7C);
        chk_bits("w12345678", 145, 16, 16'h1256, 16'h3478);
        chk_bits("w01234567", 161, 16, 16'h0145, 16'h2367);
        chk_bits("w89ABCDEF", 177, 16, 16'h89CD, 16'hABEF);
        chk_bits("w00FF00FF", 193, 16, 16'h0000, 16'hFFFF);
        chk_bits("idle_after", 209, 16, 16'h7C7C, 16'h7C7C);
        chk_bits("idle_pre_a5", 225, 16, 16'h7C7C, 16'h7C7C);
        chk_bits("a5_partial", 241, 8, 16'h00A5, 16'h00C3);
        for (int s = 0; s < 4; s++) chk_bits("recom_burst", base + 1 + 16 * s, 16, 16'hBCBC, 16'hBCBC);
        chk_bits("held_dropped0", base + 65, 16, 16'h7C7C, 16'h7C7C);
        chk_bits("held_dropped1", base + 81, 16, 16'h7C7C, 16'h7C7C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
